ppu_vram_arbiter: RTL and testbench

- Shares the PPU's single VRAM port between two requesters: the background/sprite fetch engine and the CPU-side PPUDATA ($2007) accessor.
- Fetches always win. CPU reads and writes are slotted into idle cycles.
- Implements the PPUDATA read buffer, including the palette-read buffer refill from the underlying nametable mirror.
- Sits between the PPU core and the VRAM/palette memory.

---
 rtl/ppu_vram_arbiter_if.sv | 36 +++
 rtl/ppu_vram_arbiter.sv | 133 +++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_vram_arbiter_if.sv
// ppu_vram_arbiter_if: requester and memory-side signals of the PPU VRAM arbiter.
//   fetch_*  : background/sprite fetch engine (request, address, returned data)
//   cpu_*    : PPUDATA accessor (level request held until cpu_ack, result, busy)
//   vram_*   : single VRAM/palette port (address, write strobe/data, read data)
// master = PPU core plus memory side, slave = arbiter.
interface ppu_vram_arbiter_if;
  logic        fetch_req;
  logic [13:0] fetch_addr;
  logic        fetch_valid;
  logic [7:0]  fetch_data;

  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;

  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  modport master (
    output fetch_req, fetch_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  fetch_valid, fetch_data, cpu_ack, cpu_rdata, cpu_busy,
           vram_addr, vram_we, vram_wdata
  );

  modport slave (
    input  fetch_req, fetch_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output fetch_valid, fetch_data, cpu_ack, cpu_rdata, cpu_busy,
           vram_addr, vram_we, vram_wdata
  );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the single VRAM port between the fetch engine and
// the PPUDATA accessor. Fetches always win; CPU accesses use idle slots.
// Implements the PPUDATA read buffer, including the refill from the
// nametable mirror underneath a palette read.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   i_render_active   : PPU rendering; gates CPU slots unless CPU_DURING_RENDER
//   bus (slave)       : fetch, CPU and VRAM signal groups
module ppu_vram_arbiter #(
  parameter logic [13:0] PAL_BASE          = 14'h3F00,
  parameter logic [13:0] PAL_MIRROR_MASK   = 14'h2FFF,
  parameter bit          CPU_DURING_RENDER = 1'b0,
  parameter logic [7:0]  READBUF_RESET     = 8'h00
) (
  input  logic clock,
  input  logic reset,
  input  logic i_render_active,
  ppu_vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    WR_ACK    = 3'd2,
    PAL_FILL  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;

  state_t      r_state;
  logic [13:0] r_addr;
  logic [7:0]  r_read_buf;
  logic [13:0] r_vram_addr;
  logic        r_fetch_valid;

  logic        w_render_ok;
  logic        w_cpu_slot;
  logic        w_rd_pal;
  logic [13:0] w_vram_addr;
  logic        w_vram_we;
  logic [7:0]  w_vram_wdata;
  logic        w_cpu_ack;
  logic [7:0]  w_cpu_rdata;

  // A CPU slot exists only when the fetch engine leaves the port idle.
  assign w_render_ok = !i_render_active || CPU_DURING_RENDER;
  assign w_cpu_slot  = !bus.fetch_req && w_render_ok &&
                       (((r_state == IDLE) && bus.cpu_req) || (r_state == PAL_FILL));
  assign w_rd_pal    = (r_addr >= PAL_BASE);

  // Port mux and completion outputs; everything forced low while in reset.
  always_comb begin
    w_vram_addr  = r_vram_addr;
    w_vram_we    = 1'b0;
    w_vram_wdata = 8'h00;
    w_cpu_ack    = 1'b0;
    w_cpu_rdata  = 8'h00;
    if (bus.fetch_req) begin
      w_vram_addr = bus.fetch_addr;
    end else if (w_cpu_slot) begin
      if (r_state == PAL_FILL) begin
        w_vram_addr = r_addr & PAL_MIRROR_MASK;
      end else begin
        w_vram_addr  = bus.cpu_addr;
        w_vram_we    = bus.cpu_we;
        w_vram_wdata = bus.cpu_we ? bus.cpu_wdata : 8'h00;
      end
    end
    if (r_state == RD_WAIT) begin
      w_cpu_ack   = 1'b1;
      // Palette reads bypass the buffer; others return the previous buffer.
      w_cpu_rdata = w_rd_pal ? bus.vram_rdata : r_read_buf;
    end else if (r_state == WR_ACK) begin
      w_cpu_ack = 1'b1;
    end
    if (reset) begin
      w_vram_addr  = 14'h0000;
      w_vram_we    = 1'b0;
      w_vram_wdata = 8'h00;
      w_cpu_ack    = 1'b0;
      w_cpu_rdata  = 8'h00;
    end
  end

  assign bus.vram_addr   = w_vram_addr;
  assign bus.vram_we     = w_vram_we;
  assign bus.vram_wdata  = w_vram_wdata;
  assign bus.cpu_ack     = w_cpu_ack;
  assign bus.cpu_rdata   = w_cpu_rdata;
  assign bus.cpu_busy    = !reset && (bus.cpu_req || (r_state != IDLE));
  assign bus.fetch_valid = !reset && r_fetch_valid;
  assign bus.fetch_data  = (!reset && r_fetch_valid) ? bus.vram_rdata : 8'h00;

  // CPU transaction sequencer, read buffer and address hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= 14'h0000;
      r_read_buf    <= READBUF_RESET;
      r_vram_addr   <= 14'h0000;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= bus.fetch_req;
      r_vram_addr   <= w_vram_addr;
      case (r_state)
        IDLE: begin
          if (w_cpu_slot) begin
            r_addr  <= bus.cpu_addr;
            r_state <= bus.cpu_we ? WR_ACK : RD_WAIT;
          end
        end
        RD_WAIT: begin
          // vram_rdata here belongs to the CPU read granted last cycle.
          if (w_rd_pal) begin
            r_state <= PAL_FILL;
          end else begin
            r_read_buf <= bus.vram_rdata;
            r_state    <= IDLE;
          end
        end
        WR_ACK: r_state <= IDLE;
        PAL_FILL: begin
          if (w_cpu_slot) r_state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          r_read_buf <= bus.vram_rdata;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: table-driven, hand-sequenced and randomized checks of
// ppu_vram_arbiter against a transaction-level model (memory image + buffer).
module tb_ppu_vram_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic render_active;
  logic mem_init;

  always #5 clock = ~clock;

  ppu_vram_arbiter_if bus ();

  ppu_vram_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .i_render_active (render_active),
    .bus             (bus.slave)
  );

  // VRAM environment: one-cycle read latency, write on strobe.
  logic [7:0] mem     [16384];
  logic [7:0] ref_mem [16384];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= ref_mem[i];
    end else if (bus.vram_we) begin
      mem[bus.vram_addr] <= bus.vram_wdata;
    end
    bus.vram_rdata <= mem[bus.vram_addr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic exd(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic ex(input string tag, input logic [13:0] e_addr, input logic e_we,
                    input logic e_ack, input logic e_busy, input logic e_fv);
    chk({tag, " vram_addr"},   32'(bus.vram_addr),   32'(e_addr));
    chk({tag, " vram_we"},     32'(bus.vram_we),     32'(e_we));
    chk({tag, " cpu_ack"},     32'(bus.cpu_ack),     32'(e_ack));
    chk({tag, " cpu_busy"},    32'(bus.cpu_busy),    32'(e_busy));
    chk({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(e_fv));
  endtask

  // One clock: drive after the rising edge, return at the falling edge.
  task automatic step(input logic rst, input logic ra, input logic fr, input logic [13:0] fa,
                      input logic cr, input logic cw, input logic [13:0] ca, input logic [7:0] cd);
    @(posedge clock);
    #1;
    reset          = rst;
    render_active  = ra;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.cpu_req    = cr;
    bus.cpu_we     = cw;
    bus.cpu_addr   = ca;
    bus.cpu_wdata  = cd;
    @(negedge clock);
  endtask

  typedef struct {
    logic rst; logic ra; logic fr; logic [13:0] fa;
    logic cr; logic cw; logic [13:0] ca; logic [7:0] cd;
    logic [13:0] e_addr; logic e_we; logic [7:0] e_wd; logic e_ack;
    logic e_rdchk; logic [7:0] e_rd; logic e_busy; logic e_fv; logic [7:0] e_fd;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic ra, input logic fr, input logic [13:0] fa,
    input logic cr, input logic cw, input logic [13:0] ca, input logic [7:0] cd,
    input logic [13:0] e_addr, input logic e_we, input logic [7:0] e_wd, input logic e_ack,
    input logic e_rdchk, input logic [7:0] e_rd, input logic e_busy, input logic e_fv,
    input logic [7:0] e_fd);
    vec_t r;
    r.rst = rst; r.ra = ra; r.fr = fr; r.fa = fa; r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.e_addr = e_addr; r.e_we = e_we; r.e_wd = e_wd; r.e_ack = e_ack; r.e_rdchk = e_rdchk;
    r.e_rd = e_rd; r.e_busy = e_busy; r.e_fv = e_fv; r.e_fd = e_fd;
    return r;
  endfunction

  vec_t tbl [11];

  // Random-phase state.
  logic        m_buf;
  logic [7:0]  mbuf;
  logic        pend;
  logic        t_we;
  logic [13:0] t_addr;
  logic [7:0]  t_wd;
  logic [7:0]  exp_rd;
  int          wait_cnt;
  logic        pfr, rfr, rra;
  logic [13:0] pfa, rfa;
  string       tag;

  initial begin
    reset = 1'b1; render_active = 1'b0; mem_init = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    m_buf = 1'b0;

    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'($urandom);
    ref_mem[14'h2000] = 8'hA5;
    ref_mem[14'h2001] = 8'h3C;
    ref_mem[14'h3F05] = 8'h16;
    ref_mem[14'h2F05] = 8'h77;
    for (int i = 0; i < 8; i++) ref_mem[14'h1230 + 14'(i)] = 8'h40 + 8'(i);
    @(posedge clock); #1; mem_init = 1'b1;
    @(posedge clock); #1; mem_init = 1'b0;
    @(negedge clock);

    // Buffered reads, render-gated write, then completion.
    //          rst ra fr fa       cr cw ca        cd     e_addr   we wd     ack rc rd     busy fv fd
    tbl[0]  = v(1, 0, 0, 14'h0,    0, 0, 14'h0,    8'h00, 14'h0,    0, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00);
    tbl[1]  = v(0, 0, 0, 14'h0,    1, 0, 14'h2000, 8'h00, 14'h2000, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00);
    tbl[2]  = v(0, 0, 1, 14'h1230, 1, 0, 14'h2000, 8'h00, 14'h1230, 0, 8'h00, 1, 1, 8'h00, 1, 0, 8'h00);
    tbl[3]  = v(0, 0, 0, 14'h0,    1, 0, 14'h2001, 8'h00, 14'h2001, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h40);
    tbl[4]  = v(0, 0, 0, 14'h0,    1, 0, 14'h2001, 8'h00, 14'h2001, 0, 8'h00, 1, 1, 8'hA5, 1, 0, 8'h00);
    tbl[5]  = v(0, 0, 0, 14'h0,    1, 0, 14'h2000, 8'h00, 14'h2000, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00);
    tbl[6]  = v(0, 0, 0, 14'h0,    1, 0, 14'h2000, 8'h00, 14'h2000, 0, 8'h00, 1, 1, 8'h3C, 1, 0, 8'h00);
    tbl[7]  = v(0, 1, 0, 14'h0,    1, 1, 14'h2002, 8'h99, 14'h2000, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00);
    tbl[8]  = v(0, 0, 0, 14'h0,    1, 1, 14'h2002, 8'h99, 14'h2002, 1, 8'h99, 0, 0, 8'h00, 1, 0, 8'h00);
    tbl[9]  = v(0, 0, 0, 14'h0,    1, 1, 14'h2002, 8'h99, 14'h2002, 0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00);
    tbl[10] = v(0, 0, 0, 14'h0,    0, 0, 14'h0,    8'h00, 14'h2002, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].ra, tbl[i].fr, tbl[i].fa, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd);
      tag = $sformatf("tbl[%0d]", i);
      ex(tag, tbl[i].e_addr, tbl[i].e_we, tbl[i].e_ack, tbl[i].e_busy, tbl[i].e_fv);
      if (tbl[i].e_we)    exd({tag, " vram_wdata"}, bus.vram_wdata, tbl[i].e_wd);
      if (tbl[i].e_rdchk) exd({tag, " cpu_rdata"},  bus.cpu_rdata,  tbl[i].e_rd);
      if (tbl[i].e_fv)    exd({tag, " fetch_data"}, bus.fetch_data, tbl[i].e_fd);
    end
    ref_mem[14'h2002] = 8'h99;

    // Palette read and nametable refill (buffer currently 8'hA5).
    step(0, 0, 0, 14'h0, 1, 0, 14'h3F05, 8'h00); ex("pal grant", 14'h3F05, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h3F05, 8'h00); ex("pal ack", 14'h3F05, 0, 1, 1, 0);
    exd("pal rdata", bus.cpu_rdata, 8'h16);
    step(0, 0, 0, 14'h0, 0, 0, 14'h0, 8'h00);    ex("pal fill", 14'h2F05, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 0, 0, 14'h0, 8'h00);    ex("pal fillwait", 14'h2F05, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2000, 8'h00); ex("pal next grant", 14'h2000, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2000, 8'h00); ex("pal next ack", 14'h2000, 0, 1, 1, 0);
    exd("pal refilled buf", bus.cpu_rdata, 8'h77);

    // Fetches interleaved with RD_WAIT, PAL_FILL and FILL_WAIT.
    step(0, 0, 0, 14'h0,    1, 0, 14'h3F05, 8'h00); ex("il grant", 14'h3F05, 0, 0, 1, 0);
    step(0, 0, 1, 14'h1231, 1, 0, 14'h3F05, 8'h00); ex("il rdwait", 14'h1231, 0, 1, 1, 0);
    exd("il rdata", bus.cpu_rdata, 8'h16);
    step(0, 0, 1, 14'h1232, 0, 0, 14'h0, 8'h00);    ex("il palfill busy", 14'h1232, 0, 0, 1, 1);
    exd("il fetch 1231", bus.fetch_data, 8'h41);
    step(0, 0, 0, 14'h0,    0, 0, 14'h0, 8'h00);    ex("il fill", 14'h2F05, 0, 0, 1, 1);
    exd("il fetch 1232", bus.fetch_data, 8'h42);
    step(0, 0, 1, 14'h1233, 0, 0, 14'h0, 8'h00);    ex("il fillwait", 14'h1233, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0,    1, 0, 14'h2000, 8'h00); ex("il next grant", 14'h2000, 0, 0, 1, 1);
    exd("il fetch 1233", bus.fetch_data, 8'h43);
    step(0, 0, 0, 14'h0,    1, 0, 14'h2000, 8'h00); ex("il next ack", 14'h2000, 0, 1, 1, 0);
    exd("il refilled buf", bus.cpu_rdata, 8'h77);

    // Fetch priority over a pending write.
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 14'h1230 + 14'(i), 1, 1, 14'h2100, 8'h5A);
      tag = $sformatf("prio[%0d]", i);
      ex(tag, 14'h1230 + 14'(i), 0, 0, 1, (i > 0));
      if (i > 0) exd({tag, " fetch_data"}, bus.fetch_data, 8'h40 + 8'(i - 1));
    end
    step(0, 0, 0, 14'h0, 1, 1, 14'h2100, 8'h5A); ex("prio write", 14'h2100, 1, 0, 1, 1);
    exd("prio wdata", bus.vram_wdata, 8'h5A);
    exd("prio last fetch", bus.fetch_data, 8'h47);
    step(0, 0, 0, 14'h0, 1, 1, 14'h2100, 8'h5A); ex("prio ack", 14'h2100, 0, 1, 1, 0);
    ref_mem[14'h2100] = 8'h5A;
    step(0, 0, 0, 14'h0, 1, 0, 14'h2100, 8'h00); ex("prio rd grant", 14'h2100, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2100, 8'h00); ex("prio rd ack", 14'h2100, 0, 1, 1, 0);
    exd("prio rd old buf", bus.cpu_rdata, 8'hA5);

    // Render gating holds the read; grant in the cycle render_active falls.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 14'h0, 1, 0, 14'h2001, 8'h00);
      ex($sformatf("gate[%0d]", i), 14'h2100, 0, 0, 1, 0);
    end
    step(0, 0, 0, 14'h0, 1, 0, 14'h2001, 8'h00); ex("gate grant", 14'h2001, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2001, 8'h00); ex("gate ack", 14'h2001, 0, 1, 1, 0);
    exd("gate rdata", bus.cpu_rdata, 8'h5A);

    // Reset while in RD_WAIT drops the read and clears the buffer.
    step(0, 0, 0, 14'h0, 1, 0, 14'h2000, 8'h00); ex("rst grant", 14'h2000, 0, 0, 1, 0);
    step(1, 0, 0, 14'h0, 0, 0, 14'h0, 8'h00);    ex("rst rdwait", 14'h0, 0, 0, 0, 0);
    exd("rst rdata", bus.cpu_rdata, 8'h00);
    exd("rst fetch_data", bus.fetch_data, 8'h00);
    step(1, 0, 0, 14'h0, 0, 0, 14'h0, 8'h00);    ex("rst hold", 14'h0, 0, 0, 0, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2001, 8'h00); ex("rst post grant", 14'h2001, 0, 0, 1, 0);
    step(0, 0, 0, 14'h0, 1, 0, 14'h2001, 8'h00); ex("rst post ack", 14'h2001, 0, 1, 1, 0);
    exd("rst post rdata", bus.cpu_rdata, 8'h00);

    // Randomized traffic against the transaction-level model.
    mbuf = 8'h3C; pend = 1'b0; t_we = 1'b0; t_addr = '0; t_wd = '0;
    wait_cnt = 0; pfr = 1'b0; pfa = '0;
    for (int c = 0; c < 3000; c++) begin
      rfr = ($urandom_range(99) < 40);
      rfa = 14'($urandom_range(16'h1FFF));
      rra = ($urandom_range(99) < 10);
      if (!pend && ($urandom_range(99) < 60)) begin
        pend = 1'b1;
        t_we = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) t_addr = 14'h3F00 + 14'($urandom_range(31));
        else                        t_addr = 14'h2000 + 14'($urandom_range(16'h1FFF));
        t_wd = 8'($urandom);
        wait_cnt = 0;
      end
      step(0, rra, rfr, rfa, pend, pend && t_we, pend ? t_addr : 14'h0, pend ? t_wd : 8'h00);
      chk("rnd fetch_valid", 32'(bus.fetch_valid), 32'(pfr));
      if (pfr) exd("rnd fetch_data", bus.fetch_data, ref_mem[pfa]);
      if (bus.vram_we) begin
        chk("rnd write owner", 32'(pend && t_we), 32'd1);
        chk("rnd write addr", 32'(bus.vram_addr), 32'(t_addr));
        exd("rnd write data", bus.vram_wdata, t_wd);
      end
      if (bus.cpu_ack) begin
        chk("rnd ack owner", 32'(pend), 32'd1);
        if (pend && !t_we) begin
          if (t_addr >= 14'h3F00) begin
            exp_rd = ref_mem[t_addr];
            mbuf   = ref_mem[t_addr & 14'h2FFF];
          end else begin
            exp_rd = mbuf;
            mbuf   = ref_mem[t_addr];
          end
          exd("rnd cpu_rdata", bus.cpu_rdata, exp_rd);
        end else if (pend) begin
          ref_mem[t_addr] = t_wd;
        end
        pend = 1'b0;
      end else if (pend) begin
        wait_cnt++;
        if (wait_cnt > 1000) begin
          chk("rnd ack timeout", 32'd0, 32'd1);
          pend = 1'b0;
        end
      end
      pfr = rfr;
      pfa = rfa;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
